// File: rtl/biphasemark_pkg.sv
// biphasemark_pkg: preamble patterns, framing constants and FSM states shared by the biphase-mark encoder and decoder
package biphasemark_pkg;
  localparam logic [7:0] START0 = 8'b11101000;
  localparam logic [7:0] START1 = 8'b00010111;
  localparam logic [7:0] LEFT0  = 8'b11100010;
  localparam logic [7:0] LEFT1  = 8'b00011101;
  localparam logic [7:0] RIGHT0 = 8'b11100100;
  localparam logic [7:0] RIGHT1 = 8'b00011011;
  localparam int SUBFRAME_HALFBITS = 64;
  localparam int PREAMBLE_HALFBITS = 8;
  localparam int FRAMES_PER_BLOCK  = 192;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} bmc_state_t;
  function automatic logic [7:0] preamble_sel(input logic left, input logic blk_start, input logic lvl);
    return !left ? (lvl ? RIGHT1 : RIGHT0) : blk_start ? (lvl ? START1 : START0) : (lvl ? LEFT1 : LEFT0);
  endfunction
endpackage

// File: rtl/halfbit_tick_gen.sv
// halfbit_tick_gen: divides clk down to one tick per output half-bit, parked at zero while disabled
module halfbit_tick_gen #(
  parameter int CLKS_PER_HALFBIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = CLKS_PER_HALFBIT > 1 ? $clog2(CLKS_PER_HALFBIT) : 1;
  logic [CW-1:0] r_cnt;
  logic          w_term;
  assign w_term = r_cnt == CW'(CLKS_PER_HALFBIT - 1);
  assign o_tick = i_en && w_term;
  // Count clocks within a half-bit, restarting from zero whenever the encoder is idle
  always_ff @(posedge clk)
    if (rst || !i_en) r_cnt <= '0;
    else r_cnt <= w_term ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/biphasemark_encode.sv
// biphasemark_encode: frames L/R sample pairs into S/PDIF subframes and serializes them as biphase-mark half-bits
module biphasemark_encode
  import biphasemark_pkg::*;
#(
  parameter int          CLKS_PER_HALFBIT = 1,
  parameter logic [31:0] CHAN_STATUS      = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] din_left,
  input  logic [23:0] din_right,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        dout,
  output logic        vout,
  output logic [7:0]  frame_counter,
  output logic        channel
);
  bmc_state_t  r_state, w_state_nxt;
  logic [5:0]  r_pos;
  logic        r_ready, r_started, r_wv, r_dout, r_vout, r_channel;
  logic [23:0] r_pl, r_pr, r_wl, r_wr;
  logic [7:0]  r_fc, r_pre, w_fc_nxt, w_pre;
  logic [26:0] w_data;
  logic [31:0] w_word;
  logic [4:0]  w_idx;
  logic        w_tick, w_take, w_sf_start, w_next_left, w_left_start, w_c, w_dout_nxt;

  halfbit_tick_gen #(.CLKS_PER_HALFBIT(CLKS_PER_HALFBIT)) u_tick (
    .clk(clk), .rst(rst), .i_en(r_state != IDLE), .o_tick(w_tick)
  );

  assign w_take       = din_valid && r_ready;
  assign w_sf_start   = w_tick && r_state == PREAMBLE && r_pos == 6'd0;
  assign w_next_left  = !r_started || r_channel;
  assign w_left_start = w_sf_start && w_next_left;
  assign w_fc_nxt     = !r_started ? 8'd0 : r_fc == 8'(FRAMES_PER_BLOCK - 1) ? 8'd0 : r_fc + 8'd1;
  assign w_pre        = preamble_sel(w_next_left, w_fc_nxt == 8'd0, r_dout);
  assign w_c          = r_fc < 8'd32 && CHAN_STATUS[r_fc[4:0]];
  assign w_data       = {w_c, 1'b0, r_wv, r_channel ? r_wr : r_wl};
  assign w_word       = {4'b0, ^w_data, w_data};
  assign w_idx        = r_pos[5:1] - 5'(PREAMBLE_HALFBITS / 2);

  assign din_ready     = r_ready;
  assign dout          = r_dout;
  assign vout          = r_vout;
  assign frame_counter = r_fc;
  assign channel       = r_channel;

  // State register
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;

  // Next state: leave IDLE on the first pair, then alternate preamble and data forever
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) w_state_nxt = w_take ? PREAMBLE : IDLE;
    else if (w_tick && r_pos == 6'(PREAMBLE_HALFBITS - 1)) w_state_nxt = DATA;
    else if (w_tick && r_pos == 6'(SUBFRAME_HALFBITS - 1)) w_state_nxt = PREAMBLE;
  end

  // Next half-bit: latched preamble MSB first, then BMC data where the first half always inverts
  always_comb begin
    w_dout_nxt = r_dout;
    if (r_state == PREAMBLE) w_dout_nxt = r_pos == 6'd0 ? w_pre[7] : r_pre[~r_pos[2:0]];
    else if (r_state == DATA) w_dout_nxt = r_pos[0] ? r_dout ^ w_word[w_idx] : ~r_dout;
  end

  // Buffering, subframe bookkeeping and the serializer registers
  always_ff @(posedge clk)
    if (rst) begin
      r_pos     <= '0;
      r_ready   <= 1'b1;
      r_started <= 1'b0;
      r_dout    <= 1'b0;
      r_vout    <= 1'b0;
      r_channel <= 1'b0;
      r_fc      <= '0;
    end else begin
      r_vout  <= w_tick;
      r_ready <= w_take ? 1'b0 : w_left_start ? 1'b1 : r_ready;
      if (w_take) begin
        r_pl <= din_left;
        r_pr <= din_right;
      end
      if (w_tick) begin
        r_pos  <= r_pos + 6'd1;
        r_dout <= w_dout_nxt;
      end
      if (w_sf_start) begin
        r_pre     <= w_pre;
        r_channel <= !w_next_left;
        r_started <= 1'b1;
      end
      if (w_left_start) begin
        r_fc <= w_fc_nxt;
        r_wl <= r_ready ? 24'd0 : r_pl;
        r_wr <= r_ready ? 24'd0 : r_pr;
        r_wv <= r_ready;
      end
    end
endmodule

// File: doc/biphasemark_encode.md
# biphasemark_encode

Biphase-mark (S/PDIF-style) line encoder: the transmit end of the optical audio link. It accepts left/right 24-bit sample pairs over a valid/ready handshake and frames each pair into two 64-half-bit subframes (B/M/W preamble, 24 audio bits, V/U/C/P). It emits one BMC half-bit per tick on `dout`/`vout`. Its output is the `vin`/`din` stream that `biphasemark_decode` consumes.

## Interface
- `CLKS_PER_HALFBIT`, default 1: `clk` cycles per output half-bit; must be ≥1.
- `CHAN_STATUS`, default 32'h0: C bit for frame i (i<32) is `CHAN_STATUS[i]`; C=0 for frames 32–191.
- `clk` in 1: single clock.
- `rst` in 1: synchronous reset, active-high.
- `din_left` in 24: left sample, two's complement.
- `din_right` in 24: right sample.
- `din_valid` in 1: sample pair offered.
- `din_ready` out 1: pending buffer empty; transfer happens when `din_valid && din_ready`.
- `dout` out 1: current half-bit level.
- `vout` out 1: `dout` carries a new half-bit this cycle.
- `frame_counter` out 8: frame index of the current subframe, 0–191.
- `channel` out 1: 0 = left subframe, 1 = right subframe.

## Operation
- Buffering: one pending pair register plus one working pair register.
  - Handshake loads pending; `din_ready` drops the next cycle.
  - Pending moves to working on the first tick of every left preamble.
  - `din_ready` rises the cycle after that move.
- FSM states:
  - IDLE: after reset. Moves to PREAMBLE on the first handshake.
  - PREAMBLE: 8 half-bits.
  - DATA: 56 half-bits.
  - After the 56th DATA half-bit, returns to PREAMBLE. The encoder never returns to IDLE except on `rst`.
- Preamble selection, sent MSB first:
  - Left subframe with frame 0: START0 = 11101000 / START1 = 00010111.
  - Other left subframes: LEFT0 = 11100010 / LEFT1 = 00011101.
  - Right subframes: RIGHT0 = 11100100 / RIGHT1 = 00011011.
  - Use the x0 variant when `level`=0, otherwise x1.
- `level`: the last emitted half-bit.
- Data bits, 28 per subframe, in order:
  - audio[0]…audio[23], LSB first;
  - V (1 on underrun, else 0);
  - U (0);
  - C;
  - P (XOR of the preceding 27 bits, giving even parity).
- Per data bit:
  - first half = ~`level`;
  - second half = first half ^ bit.
- Underrun: pending is empty at a left-preamble start.
  - Working pair = 0 and V=1 for both subframes of that frame.
  - `frame_counter` still advances.
- `frame_counter` increments at each left preamble start and wraps 191→0. `channel` toggles at each preamble start.

## Timing
- Reset values:
  - `dout`=0, `vout`=0, `din_ready`=1;
  - `frame_counter`=0, `channel`=0;
  - `level`=0, pending empty, tick counter 0, state IDLE.
- `rst` mid-subframe: all of the above apply on the next edge. Partial subframes are dropped and the pending pair is discarded.
- Tick:
  - A counter 0…`CLKS_PER_HALFBIT`-1 runs while the state is not IDLE; a tick occurs at terminal count.
  - `vout` is a 1-cycle pulse per tick, or continuously high when `CLKS_PER_HALFBIT`=1.
  - `dout` holds between ticks.
- Latency: a handshake in cycle N gives the first half-bit (START0 MSB=1, `vout`=1, `frame_counter`=0, `channel`=0) in cycle N+1+`CLKS_PER_HALFBIT`.
- All outputs are registered. `frame_counter`/`channel` update in the same cycle as the first preamble half-bit.
- Handshake during a left-preamble consume cycle: the consume (and any underrun decision) uses the pre-edge pending state; the new pair lands in pending.
- Throughput: one pair per 128 ticks.

## Structure
- Package `biphasemark_pkg`:
  - six preamble constants;
  - `SUBFRAME_HALFBITS`=64, `PREAMBLE_HALFBITS`=8, `FRAMES_PER_BLOCK`=192;
  - FSM state enum.
  - The decoder migrates to this package.
- Sub-module `halfbit_tick_gen`: parameterised divider producing `tick`, held in reset while IDLE.
- The top holds the FSM, subframe assembly (28-bit word, parity) and the BMC serializer.

## Test plan
- Handshake L=24'h000001, R=24'h800000 at DIV=1 → half-bits:
  - 11101000;
  - then 10 (bit0=1);
  - then 23 bits of 11/00 pairs;
  - V/U/C bits at 0;
  - P=1;
  - right subframe starts 11100100 or 00011011 according to `level`.
- Loopback into `biphasemark_decode` with 400 random pairs → decoded 28-bit words match audio/V/U/C/P, and decoder `channel` and `frame_counter` track the encoder's.
- No second pair supplied → frame 1 carries audio=0, V=1, P=1; `din_ready` stays 1.
- Run 193 frames → frame 191 uses LEFT, frame 0 repeats START; `frame_counter` wraps 191→0.
- `CLKS_PER_HALFBIT`=4 → `vout` pulses every 4th cycle and `dout` is stable between pulses; first pulse at N+5.
- Assert `rst` at data half-bit 30 → next cycle all outputs at reset values and state IDLE; a new handshake restarts with START0.
